// File: rtl/input_router_pkt.sv
// Per-input-port route computation for the NoC router: dimension-ordered routing of head flits,
// per-VC packet tracking so body/tail flits reuse the head's route, and protocol error pulses.
module input_router_pkt #(
  parameter int unsigned ROUTER_X_ID = 0,
  parameter int unsigned ROUTER_Y_ID = 0,
  parameter int unsigned X_WIDTH     = 2,
  parameter int unsigned Y_WIDTH     = 2,
  parameter int unsigned N_VC        = 3,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned ROUTING_ALG = 0,
  localparam int unsigned VCW        = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 flit_valid_i,
  input  logic                 flit_ready_i,
  input  logic [1:0]           flit_type_i,
  input  logic [VCW-1:0]       flit_vc_i,
  input  logic [X_WIDTH-1:0]   x_dest_i,
  input  logic [Y_WIDTH-1:0]   y_dest_i,
  input  logic [LEN_WIDTH-1:0] pkt_len_i,
  output logic [4:0]           route_o,
  output logic [N_VC-1:0]      vc_busy_o,
  output logic                 err_orphan_o,
  output logic                 err_head_o,
  output logic                 err_len_o,
  output logic [VCW-1:0]       err_vc_o
);

  localparam logic [4:0] R_LOCAL = 5'b10000;
  localparam logic [4:0] R_EAST  = 5'b01000;
  localparam logic [4:0] R_WEST  = 5'b00100;
  localparam logic [4:0] R_SOUTH = 5'b00010;
  localparam logic [4:0] R_NORTH = 5'b00001;

  localparam logic [X_WIDTH-1:0]   X_ID    = X_WIDTH'(ROUTER_X_ID);
  localparam logic [Y_WIDTH-1:0]   Y_ID    = Y_WIDTH'(ROUTER_Y_ID);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  vc_state_t            state_q [N_VC];
  vc_state_t            state_d [N_VC];
  logic [LEN_WIDTH-1:0] cnt_q   [N_VC];
  logic [LEN_WIDTH-1:0] cnt_d   [N_VC];
  logic [4:0]           rtab_q  [N_VC];
  logic [4:0]           rtab_d  [N_VC];

  logic           err_orphan_d, err_head_d, err_len_d;
  logic [VCW-1:0] err_vc_d;
  logic           vc_ok, is_head, is_tail, accept;
  logic           sel_active;
  logic [4:0]     sel_route, head_route;

  // Dimension-ordered route for a head flit; unsigned coordinate compares.
  function automatic logic [4:0] calc_route(input logic [X_WIDTH-1:0] x,
                                            input logic [Y_WIDTH-1:0] y);
    logic [4:0] r;
    if (x == X_ID && y == Y_ID)  r = R_LOCAL;
    else if (ROUTING_ALG == 0) begin
      if (x > X_ID)              r = R_SOUTH;
      else if (x < X_ID)         r = R_NORTH;
      else                       r = (y < Y_ID) ? R_WEST : R_EAST;
    end else begin
      if (y > Y_ID)              r = R_EAST;
      else if (y < Y_ID)         r = R_WEST;
      else                       r = (x < X_ID) ? R_NORTH : R_SOUTH;
    end
    return r;
  endfunction

  // Decode of the presented flit and lookup of its VC's stored context.
  always_comb begin
    vc_ok      = {1'b0, flit_vc_i} < (VCW+1)'(N_VC);
    is_head    = (flit_type_i == 2'b00);
    is_tail    = (flit_type_i == 2'b10);
    accept     = flit_valid_i & flit_ready_i & vc_ok;
    head_route = calc_route(x_dest_i, y_dest_i);
    sel_active = 1'b0;
    sel_route  = '0;
    for (int v = 0; v < int'(N_VC); v++) begin
      if (flit_vc_i == VCW'(v)) begin
        sel_active = (state_q[v] == ACTIVE);
        sel_route  = rtab_q[v];
      end
    end
    route_o = '0;
    if (flit_valid_i && vc_ok) begin
      if (is_head)         route_o = head_route;
      else if (sel_active) route_o = sel_route;
    end
  end

  // Per-VC next-state logic; only the addressed VC moves, and only on accept.
  always_comb begin
    err_orphan_d = 1'b0;
    err_head_d   = 1'b0;
    err_len_d    = 1'b0;
    err_vc_d     = err_vc_o;
    for (int v = 0; v < int'(N_VC); v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
      rtab_d[v]  = rtab_q[v];
      if (accept && flit_vc_i == VCW'(v)) begin
        if (is_head) begin
          err_head_d = (state_q[v] == ACTIVE);
          rtab_d[v]  = head_route;
          cnt_d[v]   = pkt_len_i;
          state_d[v] = (pkt_len_i != '0) ? ACTIVE : IDLE;
        end else if (state_q[v] == IDLE) begin
          err_orphan_d = 1'b1;
        end else if (is_tail) begin
          err_len_d  = (cnt_q[v] != LEN_ONE);
          state_d[v] = IDLE;
        end else if (cnt_q[v] == LEN_ONE) begin
          err_len_d  = 1'b1;
          state_d[v] = IDLE;
        end else begin
          cnt_d[v] = cnt_q[v] - LEN_ONE;
        end
      end
    end
    if (err_orphan_d || err_head_d || err_len_d) err_vc_d = flit_vc_i;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < int'(N_VC); v++) begin
        state_q[v] <= IDLE;
        cnt_q[v]   <= '0;
        rtab_q[v]  <= '0;
      end
      err_orphan_o <= 1'b0;
      err_head_o   <= 1'b0;
      err_len_o    <= 1'b0;
      err_vc_o     <= '0;
    end else begin
      for (int v = 0; v < int'(N_VC); v++) begin
        state_q[v] <= state_d[v];
        cnt_q[v]   <= cnt_d[v];
        rtab_q[v]  <= rtab_d[v];
      end
      err_orphan_o <= err_orphan_d;
      err_head_o   <= err_head_d;
      err_len_o    <= err_len_d;
      err_vc_o     <= err_vc_d;
    end
  end

  always_comb begin
    for (int v = 0; v < int'(N_VC); v++) vc_busy_o[v] = (state_q[v] == ACTIVE);
  end

endmodule

// File: tb/tb_input_router_pkt.sv
// Bench for input_router_pkt at router (1,1): XY instance fully checked against a packet-level
// model, YX instance sharing the same inputs checked on head-flit routes.
module tb_input_router_pkt;

  logic       clk = 1'b0;
  logic       arst;
  logic       fv, fr;
  logic [1:0] ft, fvc, xd, yd;
  logic [7:0] plen;
  logic [4:0] route, route_yx;
  logic [2:0] busy, busy_yx;
  logic       eo, eh, el, eo_yx, eh_yx, el_yx;
  logic [1:0] evc, evc_yx;

  int n_pass = 0;
  int n_total = 0;

  input_router_pkt #(.ROUTER_X_ID(1), .ROUTER_Y_ID(1), .ROUTING_ALG(0)) dut (
    .clk(clk), .arst(arst), .flit_valid_i(fv), .flit_ready_i(fr), .flit_type_i(ft),
    .flit_vc_i(fvc), .x_dest_i(xd), .y_dest_i(yd), .pkt_len_i(plen), .route_o(route),
    .vc_busy_o(busy), .err_orphan_o(eo), .err_head_o(eh), .err_len_o(el), .err_vc_o(evc));

  input_router_pkt #(.ROUTER_X_ID(1), .ROUTER_Y_ID(1), .ROUTING_ALG(1)) dut_yx (
    .clk(clk), .arst(arst), .flit_valid_i(fv), .flit_ready_i(fr), .flit_type_i(ft),
    .flit_vc_i(fvc), .x_dest_i(xd), .y_dest_i(yd), .pkt_len_i(plen), .route_o(route_yx),
    .vc_busy_o(busy_yx), .err_orphan_o(eo_yx), .err_head_o(eh_yx), .err_len_o(el_yx),
    .err_vc_o(evc_yx));

  always #5 clk = ~clk;

  // Packet-level reference state: open flag, flits still owed, route per VC.
  bit         m_busy [3];
  int         m_rem  [3];
  logic [4:0] m_rt   [3];
  logic [4:0] exp_route, exp_yx, obs_route, obs_yx;
  logic       exp_eo, exp_eh, exp_el;
  logic [1:0] exp_evc;

  function automatic logic [4:0] ref_route(input int x, input int y, input bit yx);
    if (x == 1 && y == 1) return 5'b10000;
    if (!yx) begin
      if (x != 1) return (x > 1) ? 5'b00010 : 5'b00001;
      return (y < 1) ? 5'b00100 : 5'b01000;
    end
    if (y != 1) return (y > 1) ? 5'b01000 : 5'b00100;
    return (x < 1) ? 5'b00001 : 5'b00010;
  endfunction

  function automatic logic [2:0] exp_busy();
    return {m_busy[2], m_busy[1], m_busy[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_busy[i] = 0; m_rem[i] = 0; m_rt[i] = '0; end
    exp_eo = 0; exp_eh = 0; exp_el = 0; exp_evc = '0;
  endtask

  // Drive one cycle, sample comb route before the edge, advance the model, step past the edge.
  task automatic send(input bit v, input bit r, input logic [1:0] t, input logic [1:0] vc,
                      input logic [1:0] x, input logic [1:0] y, input logic [7:0] len);
    int  c;
    bit  head;
    fv = v; fr = r; ft = t; fvc = vc; xd = x; yd = y; plen = len;
    #1;
    obs_route = route; obs_yx = route_yx;
    c = int'(vc); head = (t == 2'b00);
    exp_route = '0;
    exp_yx    = ref_route(int'(x), int'(y), 1'b1);
    if (v && c < 3) begin
      if (head)           exp_route = ref_route(int'(x), int'(y), 1'b0);
      else if (m_busy[c]) exp_route = m_rt[c];
    end
    exp_eo = 0; exp_eh = 0; exp_el = 0;
    if (v && r && c < 3) begin
      if (head) begin
        exp_eh = m_busy[c];
        m_rt[c] = ref_route(int'(x), int'(y), 1'b0);
        m_rem[c] = int'(len);
        m_busy[c] = (len != 0);
      end else if (!m_busy[c]) begin
        exp_eo = 1;
      end else if (t == 2'b10) begin
        exp_el = (m_rem[c] != 1);
        m_busy[c] = 0;
      end else begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin exp_el = 1; m_busy[c] = 0; end
      end
      if (exp_eo || exp_eh || exp_el) exp_evc = vc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fv = 0; fr = 0; ft = 0; fvc = 0; xd = 0; yd = 0; plen = 0;
    arst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({route, busy, eo, eh, el, evc} !== 13'd0)
      $display("FAIL reset_outputs: got route=%b busy=%b eo=%b eh=%b el=%b evc=%0d, want all 0", route, busy, eo, eh, el, evc);
    else n_pass++;
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_route();
    send(1, 1, 2'b00, 2'd0, 2'd2, 2'd0, 8'd0);
    n_total++; if (obs_route !== 5'b00010) $display("FAIL xy_route_20: got %b want 00010", obs_route); else n_pass++;
    n_total++; if (obs_yx !== 5'b00100) $display("FAIL yx_route_20: got %b want 00100", obs_yx); else n_pass++;
    n_total++; if (busy !== 3'b000) $display("FAIL len0_busy: got %b want 000", busy); else n_pass++;
    send(1, 1, 2'b00, 2'd0, 2'd1, 2'd1, 8'd0);
    n_total++; if (obs_yx !== 5'b10000) $display("FAIL yx_route_local: got %b want 10000", obs_yx); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      send(1, 0, 2'b00, 2'(i % 3), 2'(i / 4), 2'(i % 4), 8'd3);
      n_total++; if (obs_route !== exp_route || obs_yx !== exp_yx)
        $display("FAIL route_sweep: dest=(%0d,%0d) got xy=%b yx=%b want xy=%b yx=%b", i/4, i%4, obs_route, obs_yx, exp_route, exp_yx);
      else n_pass++;
    end
    n_total++; if (busy !== 3'b000) $display("FAIL unaccepted_heads_busy: got %b want 000", busy); else n_pass++;
  endtask

  task automatic test_packet();
    logic [1:0] ty [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [2:0] bz [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      send(1, 1, ty[i], 2'd1, 2'd0, 2'd1, 8'd3);
      n_total++; if (obs_route !== 5'b00001) $display("FAIL pkt_route[%0d]: got %b want 00001", i, obs_route); else n_pass++;
      n_total++; if (busy !== bz[i] || {eo, eh, el} !== 3'b000)
        $display("FAIL pkt_state[%0d]: got busy=%b err=%b want busy=%b err=000", i, busy, {eo, eh, el}, bz[i]);
      else n_pass++;
    end
  endtask

  task automatic test_interleave();
    logic [1:0] ty [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [1:0] vc [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    logic [1:0] xs [5] = '{2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [1:0] ys [5] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [7:0] ln [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic [4:0] rt [5] = '{5'b00010, 5'b00100, 5'b00010, 5'b00100, 5'b00010};
    logic [2:0] bz [5] = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b000};
    for (int i = 0; i < 5; i++) begin
      send(1, 1, ty[i], vc[i], xs[i], ys[i], ln[i]);
      n_total++; if (obs_route !== rt[i] || busy !== bz[i] || {eo, eh, el} !== 3'b000)
        $display("FAIL interleave[%0d]: got route=%b busy=%b err=%b want route=%b busy=%b err=000", i, obs_route, busy, {eo, eh, el}, rt[i], bz[i]);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    send(1, 1, 2'b01, 2'd2, 2'd0, 2'd0, 8'd0);
    n_total++; if (obs_route !== 5'b00000) $display("FAIL orphan_route: got %b want 00000", obs_route); else n_pass++;
    n_total++; if ({eo, eh, el} !== 3'b100 || evc !== 2'd2) $display("FAIL orphan_pulse: got err=%b vc=%0d want 100 vc=2", {eo, eh, el}, evc); else n_pass++;
    send(0, 0, 2'b00, 2'd0, 2'd0, 2'd0, 8'd0);
    n_total++; if ({eo, eh, el} !== 3'b000 || evc !== 2'd2) $display("FAIL orphan_one_cycle: got err=%b vc=%0d want 000 vc=2", {eo, eh, el}, evc); else n_pass++;
    send(1, 1, 2'b00, 2'd0, 2'd2, 2'd2, 8'd5);
    send(1, 1, 2'b01, 2'd0, 2'd0, 2'd0, 8'd0);
    send(1, 1, 2'b10, 2'd0, 2'd0, 2'd0, 8'd0);
    n_total++; if ({eo, eh, el} !== 3'b001 || evc !== 2'd0 || busy[0] !== 1'b0)
      $display("FAIL short_tail: got err=%b vc=%0d busy0=%b want 001 vc=0 busy0=0", {eo, eh, el}, evc, busy[0]);
    else n_pass++;
    send(1, 1, 2'b00, 2'd1, 2'd0, 2'd0, 8'd1);
    send(1, 1, 2'b00, 2'd1, 2'd2, 2'd1, 8'd0);
    n_total++; if ({eo, eh, el} !== 3'b010 || evc !== 2'd1 || busy[1] !== 1'b0)
      $display("FAIL head_on_active: got err=%b vc=%0d busy1=%b want 010 vc=1 busy1=0", {eo, eh, el}, evc, busy[1]);
    else n_pass++;
    send(1, 1, 2'b01, 2'd3, 2'd2, 2'd1, 8'd0);
    n_total++; if (obs_route !== 5'b00000 || {eo, eh, el} !== 3'b000)
      $display("FAIL bad_vc: got route=%b err=%b want 00000 000", obs_route, {eo, eh, el});
    else n_pass++;
  endtask

  task automatic test_hold_reset();
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 2'b00, 2'd0, 2'd0, 2'd1, 8'd4);
      n_total++; if (obs_route !== 5'b00001 || busy !== 3'b000 || {eo, eh, el} !== 3'b000)
        $display("FAIL hold[%0d]: got route=%b busy=%b err=%b want 00001 000 000", i, obs_route, busy, {eo, eh, el});
      else n_pass++;
    end
    send(1, 1, 2'b00, 2'd0, 2'd0, 2'd1, 8'd4);
    send(1, 1, 2'b01, 2'd0, 2'd0, 2'd0, 8'd0);
    n_total++; if (busy !== 3'b001) $display("FAIL pre_reset_busy: got %b want 001", busy); else n_pass++;
    #2 arst = 1'b1;
    #1;
    n_total++; if (busy !== 3'b000) $display("FAIL async_reset_busy: got %b want 000", busy); else n_pass++;
    model_reset();
    #1 arst = 1'b0;
    send(1, 1, 2'b01, 2'd0, 2'd0, 2'd0, 8'd0);
    n_total++; if (obs_route !== 5'b00000 || {eo, eh, el} !== 3'b100 || evc !== 2'd0)
      $display("FAIL post_reset_orphan: got route=%b err=%b vc=%0d want 00000 100 0", obs_route, {eo, eh, el}, evc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] t;
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      send($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, t, 2'($urandom_range(0, 3)),
           2'($urandom), 2'($urandom), 8'($urandom_range(0, 3)));
      n_total++; if (obs_route !== exp_route || busy !== exp_busy() || {eo, eh, el} !== {exp_eo, exp_eh, exp_el} || evc !== exp_evc)
        $display("FAIL random[%0d]: got route=%b busy=%b err=%b vc=%0d want route=%b busy=%b err=%b vc=%0d",
                 i, obs_route, busy, {eo, eh, el}, evc, exp_route, exp_busy(), {exp_eo, exp_eh, exp_el}, exp_evc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_packet();
    test_interleave();
    test_errors();
    test_hold_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
